// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer and the stage units.
// master: the sequencer (drives stage starts, pc, status).
// slave : the decoder/datapath side (drives run, decoded fields, stage dones).
//   run          level request to keep issuing instructions
//   opcode       decoded opcode, valid with decode_done
//   target       absolute branch/jump target, valid with decode_done
//   alu_zero     ALU zero flag, valid with exec_done
//   *_start      one-cycle stage start pulses
//   *_done       stage completion
//   pc           current instruction address
//   busy         sequencer is working on an instruction
//   fault        sticky error flag
//   instr_count  retired instruction count
interface instr_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            run;
  logic [3:0]      opcode;
  logic [PC_W-1:0] target;
  logic            alu_zero;

  logic fetch_start, decode_start, exec_start, mem_start, wb_start;
  logic fetch_done,  decode_done,  exec_done,  mem_done,  wb_done;

  logic [PC_W-1:0] pc;
  logic            busy;
  logic            fault;
  logic [15:0]     instr_count;

  modport master (
    input  run, opcode, target, alu_zero,
    input  fetch_done, decode_done, exec_done, mem_done, wb_done,
    output fetch_start, decode_start, exec_start, mem_start, wb_start,
    output pc, busy, fault, instr_count
  );

  modport slave (
    output run, opcode, target, alu_zero,
    output fetch_done, decode_done, exec_done, mem_done, wb_done,
    input  fetch_start, decode_start, exec_start, mem_start, wb_start,
    input  pc, busy, fault, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit RISC core.
// Walks each instruction through fetch/decode/exec/mem/wb using start/done
// handshakes, resolves branch/jump targets and owns the program counter.
// Illegal opcodes (13-15) and, in watchdog builds, stalled stages fault stickily.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_sequencer_if.master (run, decoded fields, stage handshakes,
//          pc, busy, fault, instr_count)
//
// Build option: define SEQ_WATCHDOG_EN to enable a per-stage wait counter that
// faults a stage after TIMEOUT cycles without its done.
//
// All outputs are registered; no combinational input-to-output path.
module instr_sequencer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StPcupd,
    StFault
  } state_e;

  localparam logic [3:0] OpLoad  = 4'd0;
  localparam logic [3:0] OpLastAlu = 4'd9;
  localparam logic [3:0] OpBeq   = 4'd10;
  localparam logic [3:0] OpBne   = 4'd11;
  localparam logic [3:0] OpJump  = 4'd12;

  state_e          state_q, state_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            zero_q, zero_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     count_q, count_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic            fetch_start_q, fetch_start_d;
  logic            decode_start_q, decode_start_d;
  logic            exec_start_q, exec_start_d;
  logic            mem_start_q, mem_start_d;
  logic            wb_start_q, wb_start_d;
  logic            taken;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] wait_q, wait_d;
  logic            in_stage;
  logic            stage_done;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    target_d = target_q;
    zero_d   = zero_q;
    pc_d     = pc_q;
    count_d  = count_q;
    taken    = (opcode_q == OpJump) ||
               ((opcode_q == OpBeq) && zero_q) ||
               ((opcode_q == OpBne) && !zero_q);
`ifdef SEQ_WATCHDOG_EN
    in_stage   = 1'b0;
    stage_done = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
`ifdef SEQ_WATCHDOG_EN
        in_stage   = 1'b1;
        stage_done = bus.fetch_done;
`endif
        if (bus.fetch_done) state_d = StDecode;
      end
      StDecode: begin
`ifdef SEQ_WATCHDOG_EN
        in_stage   = 1'b1;
        stage_done = bus.decode_done;
`endif
        if (bus.decode_done) begin
          opcode_d = bus.opcode;
          target_d = bus.target;
          if (bus.opcode <= OpBne)       state_d = StExec;
          else if (bus.opcode == OpJump) state_d = StPcupd;
          else                           state_d = StFault;
        end
      end
      StExec: begin
`ifdef SEQ_WATCHDOG_EN
        in_stage   = 1'b1;
        stage_done = bus.exec_done;
`endif
        if (bus.exec_done) begin
          zero_d = bus.alu_zero;
          // 0/1 are load/store, 2-9 ALU, 10/11 branches.
          if (opcode_q <= 4'd1)           state_d = StMem;
          else if (opcode_q <= OpLastAlu) state_d = StWb;
          else                            state_d = StPcupd;
        end
      end
      StMem: begin
`ifdef SEQ_WATCHDOG_EN
        in_stage   = 1'b1;
        stage_done = bus.mem_done;
`endif
        if (bus.mem_done) state_d = (opcode_q == OpLoad) ? StWb : StPcupd;
      end
      StWb: begin
`ifdef SEQ_WATCHDOG_EN
        in_stage   = 1'b1;
        stage_done = bus.wb_done;
`endif
        if (bus.wb_done) state_d = StPcupd;
      end
      StPcupd: begin
        pc_d    = taken ? target_q : pc_q + PC_W'(1);
        count_d = count_q + 16'd1;
        state_d = bus.run ? StFetch : StIdle;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFault;
      end
    endcase

`ifdef SEQ_WATCHDOG_EN
    // A done on the TIMEOUT-th cycle still wins over the timeout.
    if (in_stage && !stage_done && (wait_q == CntW'(TIMEOUT))) state_d = StFault;
    // wait_q holds the 1-based cycle index within the current state.
    if (state_d != state_q)            wait_d = CntW'(1);
    else if (wait_q == CntW'(TIMEOUT)) wait_d = wait_q;
    else                               wait_d = wait_q + CntW'(1);
`endif

    // Stage states are only ever entered from a different state, so a state
    // change into a stage marks its first cycle.
    fetch_start_d  = (state_d == StFetch)  && (state_q != StFetch);
    decode_start_d = (state_d == StDecode) && (state_q != StDecode);
    exec_start_d   = (state_d == StExec)   && (state_q != StExec);
    mem_start_d    = (state_d == StMem)    && (state_q != StMem);
    wb_start_d     = (state_d == StWb)     && (state_q != StWb);
    busy_d         = (state_d != StIdle) && (state_d != StFault);
    fault_d        = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      opcode_q       <= 4'd0;
      target_q       <= '0;
      zero_q         <= 1'b0;
      pc_q           <= '0;
      count_q        <= 16'd0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
      fetch_start_q  <= 1'b0;
      decode_start_q <= 1'b0;
      exec_start_q   <= 1'b0;
      mem_start_q    <= 1'b0;
      wb_start_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wait_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      target_q       <= target_d;
      zero_q         <= zero_d;
      pc_q           <= pc_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      fault_q        <= fault_d;
      fetch_start_q  <= fetch_start_d;
      decode_start_q <= decode_start_d;
      exec_start_q   <= exec_start_d;
      mem_start_q    <= mem_start_d;
      wb_start_q     <= wb_start_d;
`ifdef SEQ_WATCHDOG_EN
      wait_q         <= wait_d;
`endif
    end
  end

  assign bus.fetch_start  = fetch_start_q;
  assign bus.decode_start = decode_start_q;
  assign bus.exec_start   = exec_start_q;
  assign bus.mem_start    = mem_start_q;
  assign bus.wb_start     = wb_start_q;
  assign bus.pc           = pc_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each issued instruction pushes its
// expected pc, count, stage mask and cycle count; a monitor pops and compares
// on every retirement.
module tb_instr_sequencer;

  logic clk;
  logic rst_n;

  instr_sequencer_if #(.PC_W(8)) bus ();

  instr_sequencer #(.PC_W(8), .TIMEOUT(15)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic [4:0]  mask;  // {wb, mem, exec, decode, fetch}
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  model_pc;
  logic [15:0] model_cnt;

  // Responder state: per-stage latency from start to done.
  logic [3:0] cur_op;
  logic [7:0] cur_tgt;
  logic       cur_z;
  int         lat[5];
  int         lat_cnt[5];
  bit         pend[5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] starts();
    return {bus.wb_start, bus.mem_start, bus.exec_start, bus.decode_start, bus.fetch_start};
  endfunction

  always_comb begin
    bus.opcode   = cur_op;
    bus.target   = cur_tgt;
    bus.alu_zero = cur_z;
  end

  always @(negedge clk) begin
    logic [4:0] st;
    logic [4:0] dn;
    st = starts();
    dn = '0;
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
      end else begin
        if (st[i]) begin
          pend[i]    = 1'b1;
          lat_cnt[i] = lat[i];
        end
        if (pend[i]) begin
          if (lat_cnt[i] == 0) begin
            dn[i]   = 1'b1;
            pend[i] = 1'b0;
          end else begin
            lat_cnt[i]--;
          end
        end
      end
    end
    bus.fetch_done  = dn[0];
    bus.decode_done = dn[1];
    bus.exec_done   = dn[2];
    bus.mem_done    = dn[3];
    bus.wb_done     = dn[4];
  end

  // Retirement monitor.
  int          cyc = 0;
  int          fetch_cyc = 0;
  int          dup = 0;
  logic [4:0]  seen = '0;
  logic [15:0] prev_cnt = '0;
  exp_t        e;

  always @(negedge clk) begin
    logic [4:0] st;
    cyc++;
    st = starts();
    if (!rst_n) begin
      prev_cnt = '0;
      seen     = '0;
      dup      = 0;
    end else begin
      if (bus.instr_count != prev_cnt) begin
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("pc", bus.pc, e.pc);
          check_eq("instr_count", bus.instr_count, e.cnt);
          check_eq("stage_mask", seen, e.mask);
          check_eq("dup_start", dup, 0);
          check_eq("cycles", cyc - fetch_cyc, e.cycles);
        end
        seen = '0;
        dup  = 0;
      end
      prev_cnt = bus.instr_count;
      if ((st & seen) != '0) dup++;
      seen = seen | st;
      if (st[0]) fetch_cyc = cyc;
    end
  end

  // Push the expected outcome, then wait for the monitor to consume it.
  task automatic issue(input logic [3:0] op, input logic [7:0] tgt, input bit z,
                       input int elat, input int mlat, input bit go);
    exp_t x;
    bit   taken;
    int   n;
    cur_op  = op;
    cur_tgt = tgt;
    cur_z   = z;
    lat[2]  = elat;
    lat[3]  = mlat;
    x.mask   = 5'b00011;
    x.cycles = 3;
    if (op <= 11) begin
      x.mask[2] = 1'b1;
      x.cycles += 1 + elat;
    end
    if (op <= 1) begin
      x.mask[3] = 1'b1;
      x.cycles += 1 + mlat;
    end
    if (op == 0 || (op >= 2 && op <= 9)) begin
      x.mask[4] = 1'b1;
      x.cycles += 1;
    end
    taken     = (op == 12) || (op == 10 && z) || (op == 11 && !z);
    model_pc  = taken ? tgt : model_pc + 8'd1;
    model_cnt = model_cnt + 16'd1;
    x.pc  = model_pc;
    x.cnt = model_cnt;
    exp_q.push_back(x);
    if (go) bus.run = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("retire_wait", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pc", bus.pc, 0);
    check_eq("rst_count", bus.instr_count, 0);
    check_eq("rst_fault", bus.fault, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_starts", starts(), 0);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_pc  = 8'd0;
    model_cnt = 16'd0;
    exp_q.delete();
  endtask

  task automatic wait_fault(input string tag);
    int n;
    n = 0;
    while (!bus.fault && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, bus.fault, 1);
    check_eq("fault_busy", bus.busy, 0);
    check_eq("fault_pc", bus.pc, model_pc);
    check_eq("fault_count", bus.instr_count, model_cnt);
  endtask

  initial begin
    int         n;
    logic [4:0] any;
    rst_n   = 1'b0;
    bus.run = 1'b0;
    cur_op  = 4'd0;
    cur_tgt = 8'd0;
    cur_z   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lat[i]  = 0;
      pend[i] = 1'b0;
    end
    model_pc  = 8'd0;
    model_cnt = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("init_pc", bus.pc, 0);
    check_eq("init_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd2,  8'h00, 1'b0, 0, 0, 1'b1);  // ALU add
    issue(4'd10, 8'h40, 1'b1, 0, 0, 1'b0);  // BEQ taken
    issue(4'd10, 8'h70, 1'b0, 0, 0, 1'b0);  // BEQ not taken
    issue(4'd11, 8'h70, 1'b1, 0, 0, 1'b0);  // BNE not taken
    issue(4'd11, 8'h80, 1'b0, 0, 0, 1'b0);  // BNE taken
    issue(4'd12, 8'hFF, 1'b0, 0, 0, 1'b0);  // jump to last address
    issue(4'd5,  8'h00, 1'b0, 0, 0, 1'b0);  // ALU, pc wraps to 0
    issue(4'd12, 8'h10, 1'b0, 0, 0, 1'b0);  // jump
    issue(4'd0,  8'h00, 1'b0, 0, 4, 1'b0);  // load, mem_done 4 late
    issue(4'd1,  8'h00, 1'b0, 0, 0, 1'b0);  // store
    issue(4'd9,  8'h00, 1'b0, 3, 0, 1'b0);  // ALU, slow exec
`ifdef SEQ_WATCHDOG_EN
    issue(4'd3,  8'h00, 1'b0, 14, 0, 1'b0); // done on the last allowed cycle
`else
    issue(4'd3,  8'h00, 1'b0, 20, 0, 1'b0); // long wait, no watchdog
`endif

    // Drop run mid-instruction: it retires and the sequencer parks in IDLE.
    bus.run = 1'b0;
    issue(4'd4, 8'h00, 1'b0, 0, 0, 1'b0);
    any = '0;
    repeat (4) begin
      @(negedge clk);
      any = any | starts();
    end
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_starts", any, 0);
    check_eq("idle_pc", bus.pc, model_pc);
    issue(4'd6, 8'h00, 1'b0, 0, 0, 1'b1);

`ifdef SEQ_WATCHDOG_EN
    // Exec done withheld past the timeout.
    cur_op = 4'd3;
    lat[2] = 16;
    wait_fault("wd_fault");
    do_reset();
    lat[2] = 0;
`endif

    // Reset while waiting in MEM: pending done is dropped, restart from pc=0.
    cur_op = 4'd0;
    lat[3] = 30;
    n = 0;
    while (!bus.mem_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("mem_start_seen", bus.mem_start, 1);
    repeat (2) @(negedge clk);
    do_reset();
    lat[3] = 0;
    issue(4'd7, 8'h00, 1'b0, 0, 0, 1'b1);

    // Illegal opcode faults; nothing moves afterwards despite run=1.
    cur_op = 4'd14;
    wait_fault("illegal_fault");
    any = '0;
    repeat (10) begin
      @(negedge clk);
      any = any | starts();
    end
    check_eq("fault_starts", any, 0);
    check_eq("fault_hold", bus.fault, 1);
    check_eq("fault_pc_hold", bus.pc, model_pc);
    do_reset();
    @(negedge clk);
    check_eq("post_rst_fault", bus.fault, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the 16-bit RISC core: walks each instruction through fetch, decode, execute, memory and write-back phases using per-stage start/done handshakes, and owns the program counter. It sits above the opcode decoder and datapath units. It decides which stages an opcode visits and resolves branch and jump targets. Illegal opcodes and stalled stages drive it into a sticky fault state.

## Interface
- PC_W, 8, program counter / instruction memory address width
- TIMEOUT, 15, maximum cycles a stage may wait for its done (watchdog builds only)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep issuing instructions, 0 = stop after current instruction
- opcode  in  4  decoded opcode, sampled when decode_done=1
- target  in  PC_W  branch/jump absolute target, sampled when decode_done=1
- alu_zero  in  1  ALU zero flag, sampled when exec_done=1
- fetch_start / decode_start / exec_start / mem_start / wb_start  out  1 each  one-cycle stage start pulses
- fetch_done / decode_done / exec_done / mem_done / wb_done  in  1 each  stage completion
- pc  out  PC_W  current instruction address
- busy  out  1  1 in any state except IDLE and FAULT
- fault  out  1  sticky error flag
- instr_count  out  16  retired instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, FAULT.
- IDLE: when run=1, go to FETCH.
- Stage states pulse their *_start output on the first cycle in the state only.
  - The matching *_done is sampled every cycle in the state, including the start cycle.
  - Stage states hold until their done arrives.
- FETCH -> DECODE on fetch_done.
- DECODE, on decode_done: latch opcode and target, then route:
  - 0–11 -> EXEC
  - 12 (jump) -> PCUPD
  - 13–15 -> FAULT
- EXEC, on exec_done: latch alu_zero, then route:
  - 0 (load) and 1 (store) -> MEM
  - 2–9 (ALU ops) -> WB
  - 10 (BEQ) and 11 (BNE) -> PCUPD
- MEM, on mem_done: load -> WB; store -> PCUPD.
- WB -> PCUPD on wb_done.
- PCUPD (single cycle):
  - taken = (opcode==12) | (opcode==10 & zero) | (opcode==11 & !zero).
  - pc <= taken ? target : pc+1, modulo 2^PC_W; 2^PC_W-1 wraps to 0.
  - instr_count += 1, wrapping at 16 bits.
  - Next state: FETCH if run=1, else IDLE.
- run=0 mid-instruction: the instruction completes normally; the sequencer stops in IDLE after PCUPD.
- FAULT: all starts 0, busy=0, fault=1; pc and instr_count frozen. Only rst_n exits.
- Done inputs arriving outside their own stage state are ignored.

## Timing
- Reset (async assert, applies immediately): state=IDLE, pc=0, instr_count=0, fault=0, busy=0, all *_start=0.
- Any outputs are registered; no combinational path from inputs to outputs.
- Minimum cycles per instruction from FETCH entry, with every done returned in its start cycle:
  - ALU: 5
  - load: 6
  - store: 5
  - branch: 4
  - jump: 3
- The updated pc is visible on the cycle after PCUPD, which is the same cycle fetch_start pulses for the next instruction.
- The IDLE -> FETCH decision takes one cycle after run rises.
- rst_n asserted mid-stage: the pending done is discarded; the sequencer restarts from IDLE with pc=0.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A per-stage wait counter clears on every stage entry.
  - If a stage sees TIMEOUT cycles without its done, the next edge goes to FAULT.
  - A done on exactly cycle TIMEOUT is still accepted.
- SEQ_WATCHDOG_EN undefined: no counter; stages wait indefinitely; TIMEOUT is unused.

## Test plan
- ALU add: opcode=2, all dones immediate, run=1 from reset -> starts fetch, decode, exec, wb in consecutive cycles; pc 0->1; instr_count=1; 5 cycles.
- BEQ: opcode=10, target=0x40, alu_zero=1 -> no mem_start or wb_start; pc=0x40. Repeat with alu_zero=0 -> pc=old+1. BNE gives the inverse results.
- Jump and wrap: pc=0xFF, opcode=2 -> pc=0x00. Opcode=12, target=0x10 -> exec_start never pulses; pc=0x10 after 3 cycles.
- Load with delayed mem_done (4 cycles late) -> state holds in MEM with no repeated mem_start. Then wb_start, then pc+1. Store -> no wb_start.
- Illegal opcode 14 -> FAULT; fault=1, busy=0, pc frozen, no further starts despite run=1. rst_n low -> all outputs return to reset values.
- Watchdog builds (SEQ_WATCHDOG_EN, TIMEOUT=15):
  - exec_done withheld 16 cycles -> FAULT.
  - exec_done on cycle 15 -> normal completion.
  - Run=0 mid-WB -> instruction retires, then IDLE.
